// File: rtl/dsram_responder_pkg.sv
// Shared constants and helpers for the data-SRAM responder: MMIO offsets,
// register-select decode and byte-masked merge.
package dsram_responder_pkg;

    localparam logic [15:0] MMIO_HI_DEFAULT = 16'hBFAF;

    localparam logic [15:0] MMIO_LED    = 16'h0000;
    localparam logic [15:0] MMIO_SWITCH = 16'h0004;
    localparam logic [15:0] MMIO_TIMER  = 16'h0008;
    localparam logic [15:0] MMIO_CMP    = 16'h000C;
    localparam logic [15:0] MMIO_STATUS = 16'h0010;

    typedef enum logic [2:0] {
        SEL_LED,
        SEL_SWITCH,
        SEL_TIMER,
        SEL_CMP,
        SEL_STATUS,
        SEL_NONE
    } mmio_sel_e;

    // Byte lane bits of the offset are ignored, so decode on the word offset only.
    function automatic mmio_sel_e mmio_decode(input logic [15:0] off);
        mmio_sel_e sel;
        case ({off[15:2], 2'b00})
            MMIO_LED:    sel = SEL_LED;
            MMIO_SWITCH: sel = SEL_SWITCH;
            MMIO_TIMER:  sel = SEL_TIMER;
            MMIO_CMP:    sel = SEL_CMP;
            MMIO_STATUS: sel = SEL_STATUS;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  wen);
        logic [31:0] res;
        res = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (wen[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dsram_responder_if.sv
// CPU data-SRAM request/response bundle; the core is the master.
interface dsram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/dsram_responder_mmio.sv
// MMIO register block: LED, synchronized switches, free-running timer,
// compare register and sticky match flag, plus the combinational read mux.
module resp_mmio
    import dsram_responder_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr,
    input  logic [3:0]  i_wen,
    input  logic [15:0] i_off,
    input  logic [31:0] i_wdata,
    input  logic [7:0]  i_switch,
    output logic [31:0] o_rdata,
    output logic [15:0] o_led,
    output logic        o_irq
);

    logic [15:0] r_led;
    logic [31:0] r_timer;
    logic [31:0] r_cmp;
    logic        r_match;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;

    mmio_sel_e   w_sel;
    logic        w_match_set;
    logic        w_match_clr;
    logic        w_unused_off;

    assign w_sel        = mmio_decode(i_off);
    assign w_unused_off = ^i_off[1:0];
    assign w_match_set  = (r_timer == r_cmp);
    assign w_match_clr  = i_wr && (w_sel == SEL_STATUS) && i_wen[0] && i_wdata[0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_led     <= '0;
            r_timer   <= '0;
            r_cmp     <= '1;
            r_match   <= 1'b0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= i_switch;
            r_sw_sync <= r_sw_meta;
            if (i_wr && (w_sel == SEL_LED)) begin
                if (i_wen[0]) r_led[7:0]  <= i_wdata[7:0];
                if (i_wen[1]) r_led[15:8] <= i_wdata[15:8];
            end
            // A load replaces this edge's increment; untouched bytes keep the pre-edge value.
            if (i_wr && (w_sel == SEL_TIMER)) r_timer <= byte_merge(r_timer, i_wdata, i_wen);
            else                              r_timer <= r_timer + 32'd1;
            if (i_wr && (w_sel == SEL_CMP))   r_cmp   <= byte_merge(r_cmp, i_wdata, i_wen);
            r_match <= w_match_set | (r_match & ~w_match_clr);
        end
    end

    always_comb begin
        o_rdata = '0;
        case (w_sel)
            SEL_LED:    o_rdata = {16'h0000, r_led};
            SEL_SWITCH: o_rdata = {24'h000000, r_sw_sync};
            SEL_TIMER:  o_rdata = r_timer;
            SEL_CMP:    o_rdata = r_cmp;
            SEL_STATUS: o_rdata = {31'h0, r_match};
            default:    o_rdata = '0;
        endcase
    end

    assign o_led = r_led;
    assign o_irq = r_match;

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM slave: word-addressed local RAM plus an MMIO window, with a
// registered read-data path answering one cycle after the request.
module dsram_responder
    import dsram_responder_pkg::*;
#(
    parameter int          RAM_AW  = 12,
    parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    dsram_responder_if.slave    dsram,
    input  logic [7:0]          switch,
    output logic [15:0]         led,
    output logic                timer_irq
);

    logic [31:0]       r_mem [0:(2**RAM_AW)-1];
    logic [31:0]       r_rdata;

    logic              w_is_mmio;
    logic              w_rd;
    logic              w_wr;
    logic [RAM_AW-1:0] w_idx;
    logic [31:0]       w_mmio_rdata;

    assign w_is_mmio = (dsram.data_sram_addr[31:16] == MMIO_HI);
    assign w_idx     = dsram.data_sram_addr[RAM_AW+1:2];
    assign w_rd      = dsram.data_sram_en && (dsram.data_sram_wen == 4'h0);
    assign w_wr      = dsram.data_sram_en && (dsram.data_sram_wen != 4'h0);

    resp_mmio u_mmio (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_wr     (w_wr && w_is_mmio),
        .i_wen    (dsram.data_sram_wen),
        .i_off    (dsram.data_sram_addr[15:0]),
        .i_wdata  (dsram.data_sram_wdata),
        .i_switch (switch),
        .o_rdata  (w_mmio_rdata),
        .o_led    (led),
        .o_irq    (timer_irq)
    );

    // RAM contents survive reset, so the array lives in its own reset-free process.
    always_ff @(posedge clk) begin
        if (w_wr && !w_is_mmio) begin
            if (dsram.data_sram_wen[0]) r_mem[w_idx][7:0]   <= dsram.data_sram_wdata[7:0];
            if (dsram.data_sram_wen[1]) r_mem[w_idx][15:8]  <= dsram.data_sram_wdata[15:8];
            if (dsram.data_sram_wen[2]) r_mem[w_idx][23:16] <= dsram.data_sram_wdata[23:16];
            if (dsram.data_sram_wen[3]) r_mem[w_idx][31:24] <= dsram.data_sram_wdata[31:24];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_is_mmio ? w_mmio_rdata : r_mem[w_idx];
        end
    end

    assign dsram.data_sram_rdata = r_rdata;

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder with a transaction-level reference model
// checked every cycle, plus hand-computed spot checks.
module tb_dsram_responder;

    localparam logic [31:0] A_LED    = 32'hBFAF_0000;
    localparam logic [31:0] A_SWITCH = 32'hBFAF_0004;
    localparam logic [31:0] A_TIMER  = 32'hBFAF_0008;
    localparam logic [31:0] A_CMP    = 32'hBFAF_000C;
    localparam logic [31:0] A_STATUS = 32'hBFAF_0010;

    logic        clk;
    logic        reset;
    logic [7:0]  sw;
    logic [15:0] led;
    logic        timer_irq;

    int n_tests;
    int n_fail;

    dsram_responder_if dbus ();

    dsram_responder #(.RAM_AW(12), .MMIO_HI(16'hBFAF)) dut (
        .clk       (clk),
        .reset     (reset),
        .dsram     (dbus),
        .switch    (sw),
        .led       (led),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: timer is tracked as load value plus elapsed edges.
    logic [31:0] m_mem  [int];
    logic [3:0]  m_memk [int];
    logic [15:0] m_led;
    logic [31:0] m_cmp;
    logic        m_match;
    logic [31:0] m_tbase;
    logic [31:0] m_tedge;
    logic [31:0] m_cnt;
    logic [7:0]  m_swq [$];
    logic [31:0] m_rd;
    logic        m_rd_known;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_led      = 16'h0;
        m_cmp      = 32'hFFFF_FFFF;
        m_match    = 1'b0;
        m_tbase    = 32'h0;
        m_tedge    = m_cnt;
        m_swq.delete();
        m_rd       = 32'h0;
        m_rd_known = 1'b1;
    endtask

    task automatic model_step();
        logic [31:0] tpre, a, d;
        logic [15:0] off;
        logic [7:0]  swvis;
        logic [3:0]  w;
        logic        mm, clr;
        int          idx;
        if (reset) return;
        a     = dbus.data_sram_addr;
        d     = dbus.data_sram_wdata;
        w     = dbus.data_sram_wen;
        tpre  = m_tbase + (m_cnt - m_tedge);
        swvis = (m_swq.size() >= 2) ? m_swq[1] : 8'h00;
        mm    = (a[31:16] == 16'hBFAF);
        off   = {a[15:2], 2'b00};
        idx   = int'((a >> 2) & 32'h0000_0FFF);
        if (dbus.data_sram_en && w == 4'h0) begin
            m_rd_known = 1'b1;
            if (mm) begin
                case (off)
                    16'h0000: m_rd = {16'h0, m_led};
                    16'h0004: m_rd = {24'h0, swvis};
                    16'h0008: m_rd = tpre;
                    16'h000C: m_rd = m_cmp;
                    16'h0010: m_rd = {31'h0, m_match};
                    default:  m_rd = 32'h0;
                endcase
            end else if (m_memk.exists(idx) && m_memk[idx] == 4'hF) begin
                m_rd = m_mem[idx];
            end else begin
                m_rd_known = 1'b0;
            end
        end
        clr     = dbus.data_sram_en && mm && off == 16'h0010 && w[0] && d[0];
        m_match = (tpre == m_cmp) || (m_match && !clr);
        if (dbus.data_sram_en && w != 4'h0) begin
            if (mm) begin
                if (off == 16'h0000) begin
                    if (w[0]) m_led[7:0]  = d[7:0];
                    if (w[1]) m_led[15:8] = d[15:8];
                end else if (off == 16'h0008) begin
                    for (int i = 0; i < 4; i++) if (w[i]) tpre[8*i +: 8] = d[8*i +: 8];
                    m_tbase = tpre;
                    m_tedge = m_cnt + 32'd1;
                end else if (off == 16'h000C) begin
                    for (int i = 0; i < 4; i++) if (w[i]) m_cmp[8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                if (!m_mem.exists(idx)) begin
                    m_mem[idx]  = 32'h0;
                    m_memk[idx] = 4'h0;
                end
                for (int i = 0; i < 4; i++) begin
                    if (w[i]) begin
                        m_mem[idx][8*i +: 8] = d[8*i +: 8];
                        m_memk[idx][i]       = 1'b1;
                    end
                end
            end
        end
        m_swq.push_front(sw);
        if (m_swq.size() > 2) void'(m_swq.pop_back());
        m_cnt = m_cnt + 32'd1;
    endtask

    // One request per cycle: drive after the edge, let the model consume it at the next edge.
    task automatic cyc(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
        dbus.data_sram_en    = en;
        dbus.data_sram_wen   = wen;
        dbus.data_sram_addr  = addr;
        dbus.data_sram_wdata = wdata;
        @(posedge clk);
        model_step();
        #1;
        dbus.data_sram_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
        cyc(1'b1, wen, addr, wdata);
    endtask

    task automatic rd(input logic [31:0] addr);
        cyc(1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (m_rd_known) check("rdata", dbus.data_sram_rdata, m_rd);
        check("led", {16'h0, led}, {16'h0, m_led});
        check("timer_irq", {31'h0, timer_irq}, {31'h0, m_match});
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_cnt   = 32'h0;
        reset   = 1'b1;
        sw      = 8'h00;
        dbus.data_sram_en    = 1'b0;
        dbus.data_sram_wen   = 4'h0;
        dbus.data_sram_addr  = 32'h0;
        dbus.data_sram_wdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", dbus.data_sram_rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_irq", {31'h0, timer_irq}, 32'h0);
        reset = 1'b0;

        // Byte-masked RAM write and read-after-write.
        wr(32'h0000_0010, 4'hF, 32'h1122_3344);
        wr(32'h0000_0010, 4'b0010, 32'h0000_AA00);
        rd(32'h0000_0010);
        check("ram_bytemask", dbus.data_sram_rdata, 32'h1122_AA44);

        // Aliasing: index wraps past 2**RAM_AW words.
        wr(32'h0000_0000, 4'hF, 32'h0000_005A);
        rd(32'h0000_0000 + (32'h1 << 14));
        check("ram_alias", dbus.data_sram_rdata, 32'h0000_005A);

        for (int i = 0; i < 6; i++)
            wr(32'h0000_0100 + 32'(i * 4), 4'hF, (32'h0101_0101 * 32'(i)) ^ 32'hDEAD_0000);
        for (int i = 0; i < 6; i++) begin
            wr(32'h0000_0100 + 32'(i * 4), 4'(1 << (i % 4)), 32'h7788_99BB);
            rd(32'h0000_0100 + 32'(i * 4));
            rd(32'hFFF0_0100 + 32'(i * 4) + 32'(i % 4));
        end

        // LED and unmapped MMIO.
        wr(A_LED, 4'hF, 32'hFFFF_ABCD);
        check("led_value", {16'h0, led}, 32'h0000_ABCD);
        rd(A_LED);
        check("led_read", dbus.data_sram_rdata, 32'h0000_ABCD);
        wr(32'hBFAF_0100, 4'hF, 32'h1234_5678);
        rd(32'hBFAF_0100);
        check("unmapped_read", dbus.data_sram_rdata, 32'h0);
        wr(A_LED, 4'b0010, 32'h0000_1200);
        rd(A_LED + 32'd2);

        // Timer wrap into compare match, then clear.
        wr(A_TIMER, 4'hF, 32'hFFFF_FFFE);
        wr(A_CMP, 4'hF, 32'h0000_0001);
        idle();
        idle();
        check("irq_before_match", {31'h0, timer_irq}, 32'h0);
        idle();
        check("irq_on_match", {31'h0, timer_irq}, 32'h1);
        rd(A_STATUS);
        check("status_read", dbus.data_sram_rdata, 32'h1);
        wr(A_STATUS, 4'h1, 32'h1);
        check("irq_cleared", {31'h0, timer_irq}, 32'h0);

        // Set beats clear when both land on the same edge.
        wr(A_TIMER, 4'hF, 32'h0000_0100);
        rd(A_TIMER);
        check("timer_read", dbus.data_sram_rdata, 32'h0000_0100);
        wr(A_CMP, 4'hF, 32'h0000_0102);
        wr(A_STATUS, 4'h1, 32'h1);
        check("set_beats_clear", {31'h0, timer_irq}, 32'h1);
        wr(A_STATUS, 4'h1, 32'h1);
        check("irq_cleared2", {31'h0, timer_irq}, 32'h0);
        wr(A_TIMER, 4'b0100, 32'h00AB_0000);
        rd(A_TIMER);
        rd(A_CMP);
        wr(A_CMP, 4'b1001, 32'h5500_0066);
        rd(A_CMP);

        // Switch synchronizer latency.
        sw = 8'hA5;
        rd(A_SWITCH);
        check("switch_edge1", dbus.data_sram_rdata, 32'h0);
        rd(A_SWITCH);
        check("switch_edge2", dbus.data_sram_rdata, 32'h0);
        rd(A_SWITCH);
        check("switch_edge3", dbus.data_sram_rdata, 32'h0000_00A5);

        // Reset in the middle of a pending read.
        wr(32'h0000_0020, 4'hF, 32'hCAFE_F00D);
        rd(32'h0000_0020);
        check("pre_reset_read", dbus.data_sram_rdata, 32'hCAFE_F00D);
        dbus.data_sram_en   = 1'b1;
        dbus.data_sram_wen  = 4'h0;
        dbus.data_sram_addr = 32'h0000_0010;
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("midreset_rdata", dbus.data_sram_rdata, 32'h0);
        check("midreset_led", {16'h0, led}, 32'h0);
        check("midreset_irq", {31'h0, timer_irq}, 32'h0);
        @(posedge clk);
        model_step();
        #1;
        reset = 1'b0;
        dbus.data_sram_en = 1'b0;
        rd(32'h0000_0020);
        check("post_reset_read", dbus.data_sram_rdata, 32'hCAFE_F00D);
        rd(A_TIMER);
        rd(A_CMP);
        check("post_reset_cmp", dbus.data_sram_rdata, 32'hFFFF_FFFF);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
